uart_tx_arbiter: RTL and testbench

UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

---
 rtl/uart_tx_arbiter_if.sv | 24 ++
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between four byte requesters, the arbiter and a shared UART transmitter.
// The arbiter uses the slave modport; the surrounding environment uses master.
interface uart_tx_arbiter_if;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic        err_clr;
  logic        tx_busy;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic [3:0]  grant_ack;
  logic [1:0]  active_id;
  logic        ctrl_busy;
  logic        timeout_err;

  modport slave (
    input  req, req_data, err_clr, tx_busy,
    output tx_start, tx_data, grant_ack, active_id, ctrl_busy, timeout_err
  );

  modport master (
    output req, req_data, err_clr, tx_busy,
    input  tx_start, tx_data, grant_ack, active_id, ctrl_busy, timeout_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among four requesters.
// Issues a one-cycle start/ack and then tracks tx_busy high and low, with a timeout on the rise.
module uart_tx_arbiter #(
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  uart_tx_arbiter_if.slave  bus
);

  localparam int CNT_W = $clog2(BUSY_TIMEOUT + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT_HI = 2'd2;
  localparam logic [1:0] WAIT_LO = 2'd3;

  logic [1:0]       state_q, state_d;
  logic             tx_start_q, tx_start_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic [3:0]       grant_ack_q, grant_ack_d;
  logic [1:0]       active_id_q, active_id_d;
  logic [1:0]       last_winner_q, last_winner_d;
  logic             timeout_err_q, timeout_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0]       winner;
  logic [1:0]       cand;
  logic             found;
  logic [CNT_W-1:0] cnt_inc;

  // Search starts one past the previous winner; i == 4 wraps back onto it.
  always_comb begin
    winner = last_winner_q;
    cand   = '0;
    found  = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      cand = last_winner_q + 2'(i);
      if (!found && bus.req[cand]) begin
        winner = cand;
        found  = 1'b1;
      end
    end
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d       = state_q;
    tx_start_d    = 1'b0;
    tx_data_d     = tx_data_q;
    grant_ack_d   = 4'b0000;
    active_id_d   = active_id_q;
    last_winner_d = last_winner_q;
    timeout_err_d = timeout_err_q;
    cnt_d         = cnt_q;

    if (bus.err_clr) begin
      timeout_err_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if ((|bus.req) && !bus.tx_busy) begin
          state_d       = ISSUE;
          tx_start_d    = 1'b1;
          grant_ack_d   = 4'b0001 << winner;
          tx_data_d     = bus.req_data[{winner, 3'b000} +: 8];
          active_id_d   = winner;
          last_winner_d = winner;
        end
      end
      ISSUE: begin
        state_d = WAIT_HI;
        cnt_d   = '0;
      end
      WAIT_HI: begin
        if (bus.tx_busy) begin
          state_d = WAIT_LO;
        end else if (cnt_inc == CNT_W'(BUSY_TIMEOUT)) begin
          // A timeout outranks a simultaneous err_clr.
          state_d       = IDLE;
          timeout_err_d = 1'b1;
          cnt_d         = cnt_inc;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      WAIT_LO: begin
        if (!bus.tx_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      tx_start_q    <= 1'b0;
      tx_data_q     <= 8'h00;
      grant_ack_q   <= 4'b0000;
      active_id_q   <= 2'd0;
      last_winner_q <= 2'd3;
      timeout_err_q <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      tx_start_q    <= tx_start_d;
      tx_data_q     <= tx_data_d;
      grant_ack_q   <= grant_ack_d;
      active_id_q   <= active_id_d;
      last_winner_q <= last_winner_d;
      timeout_err_q <= timeout_err_d;
      cnt_q         <= cnt_d;
    end
  end

  assign bus.tx_start    = tx_start_q;
  assign bus.tx_data     = tx_data_q;
  assign bus.grant_ack   = grant_ack_q;
  assign bus.active_id   = active_id_q;
  assign bus.timeout_err = timeout_err_q;
  assign bus.ctrl_busy   = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single transfer, full round-robin, fairness,
// busy timeout, blocked issue and reset in the middle of a transfer.
module tb_uart_tx_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  uart_tx_arbiter_if ifc();

  uart_tx_arbiter #(.BUSY_TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cycle    = 0;
  int n_start  = 0;
  int n_overlap = 0;
  int n_badack = 0;
  int last_start_cycle = 0;
  int busy_fall_cycle  = 0;
  int ctrl_fall_cycle  = 0;
  int req_cycle = 0;
  int base;
  logic prev_ctrl_busy = 1'b0;
  bit model_en = 0, auto_drop = 0, pend = 0, busy_model = 0, busy_force = 0;
  int busy_left = 0, busy_len = 3;
  logic [1:0] log_id[$];
  logic [7:0] log_data[$];
  logic [3:0] log_ack[$];

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // One clock: sample outputs 1ns after the edge, then update requesters and the UART model.
  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
    if (ifc.tx_start) begin
      n_start++;
      last_start_cycle = cycle;
      if (ifc.tx_busy) n_overlap++;
      log_id.push_back(ifc.active_id);
      log_data.push_back(ifc.tx_data);
      log_ack.push_back(ifc.grant_ack);
    end
    if (ifc.grant_ack != (ifc.tx_start ? (4'b0001 << ifc.active_id) : 4'b0000)) n_badack++;
    if (prev_ctrl_busy && !ifc.ctrl_busy) ctrl_fall_cycle = cycle;
    prev_ctrl_busy = ifc.ctrl_busy;
    if (auto_drop) ifc.req = ifc.req & ~ifc.grant_ack;
    if (model_en) begin
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          busy_model = 0;
          busy_fall_cycle = cycle;
        end
      end else if (pend) begin
        pend = 0;
        busy_model = 1;
        busy_left = busy_len;
      end
      if (ifc.tx_start) pend = 1;
    end
    ifc.tx_busy = model_en ? busy_model : busy_force;
  endtask

  task automatic wait_starts(input int target, input int budget, input string tag);
    while (n_start < target && budget > 0) begin
      tick();
      budget--;
    end
    check_output(tag, n_start, target);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    while (ifc.ctrl_busy && budget > 0) begin
      tick();
      budget--;
    end
    check_output(tag, ifc.ctrl_busy, 1'b0);
  endtask

  task automatic reset_model();
    model_en = 0; pend = 0; busy_model = 0; busy_left = 0; busy_force = 0;
    ifc.tx_busy = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst_n = 1'b0;
    ifc.req = 4'b0000;
    ifc.req_data = 32'h0;
    ifc.err_clr = 1'b0;
    ifc.tx_busy = 1'b0;
    #12;
    check_output("rst_tx_start", ifc.tx_start, 0);
    check_output("rst_tx_data", ifc.tx_data, 8'h00);
    check_output("rst_grant_ack", ifc.grant_ack, 4'b0000);
    check_output("rst_active_id", ifc.active_id, 0);
    check_output("rst_timeout_err", ifc.timeout_err, 0);
    check_output("rst_ctrl_busy", ifc.ctrl_busy, 0);

    // Single request from requester 2, granted on the first edge after release.
    @(posedge clk); #1;
    model_en = 1; busy_len = 100; auto_drop = 1;
    ifc.req_data = 32'h005A_0000;
    ifc.req = 4'b0100;
    rst_n = 1'b1;
    req_cycle = cycle;
    wait_starts(1, 10, "single_start");
    check_output("single_latency", last_start_cycle - req_cycle, 1);
    check_output("single_data", log_data[0], 8'h5A);
    check_output("single_ack", log_ack[0], 4'b0100);
    check_output("single_id", log_id[0], 2);
    wait_idle(200, "single_idle");
    check_output("single_ctrl_fall", ctrl_fall_cycle - busy_fall_cycle, 1);
    check_output("single_count", n_start, 1);
    check_output("single_hold_data", ifc.tx_data, 8'h5A);
    check_output("single_req_dropped", ifc.req, 4'b0000);

    // All four requesters from reset: plain rotation 0,1,2,3.
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    busy_len = 3;
    base = log_id.size();
    ifc.req_data = 32'h4433_2211;
    ifc.req = 4'b1111;
    wait_starts(n_start + 4, 100, "all4_starts");
    wait_idle(50, "all4_idle");
    for (int i = 0; i < 4; i++) begin
      check_output($sformatf("all4_id%0d", i), log_id[base + i], i);
      check_output($sformatf("all4_data%0d", i), log_data[base + i], 8'h11 * (i + 1));
    end
    check_output("all4_overlap", n_overlap, 0);
    check_output("all4_req_empty", ifc.req, 4'b0000);

    // Requesters 0 and 3 held high must alternate.
    auto_drop = 0;
    base = log_id.size();
    ifc.req = 4'b1001;
    wait_starts(n_start + 4, 100, "fair_starts");
    ifc.req = 4'b0000;
    wait_idle(50, "fair_idle");
    check_output("fair_g0", log_id[base], 0);
    check_output("fair_g1", log_id[base + 1], 3);
    check_output("fair_g2", log_id[base + 2], 0);
    check_output("fair_g3", log_id[base + 3], 3);

    // tx_busy never rises: 16 cycles in WAIT_HI then back to IDLE with a sticky error.
    reset_model();
    auto_drop = 1;
    ifc.req = 4'b0001;
    wait_starts(n_start + 1, 10, "to_start");
    check_output("to_ack", log_ack[log_ack.size() - 1], 4'b0001);
    base = 0;
    while (!ifc.timeout_err && base < 40) begin
      tick();
      base++;
    end
    check_output("to_delay", cycle - last_start_cycle, 17);
    check_output("to_idle", ifc.ctrl_busy, 0);
    tick(); tick();
    check_output("to_sticky", ifc.timeout_err, 1);
    ifc.err_clr = 1'b1;
    tick();
    ifc.err_clr = 1'b0;
    check_output("to_cleared", ifc.timeout_err, 0);

    // err_clr held through a second timeout: the timeout edge still sets the flag.
    ifc.err_clr = 1'b1;
    ifc.req = 4'b0001;
    wait_starts(n_start + 1, 10, "to2_start");
    wait_idle(40, "to2_idle");
    check_output("to2_wins", ifc.timeout_err, 1);
    tick();
    check_output("to2_cleared", ifc.timeout_err, 0);
    ifc.err_clr = 1'b0;

    // External busy blocks issue; grant follows on the edge after it drops.
    busy_force = 1; ifc.tx_busy = 1'b1;
    base = n_start;
    ifc.req = 4'b0010;
    repeat (5) tick();
    check_output("blk_no_start", n_start - base, 0);
    busy_force = 0; ifc.tx_busy = 1'b0;
    req_cycle = cycle;
    wait_starts(base + 1, 10, "blk_start");
    check_output("blk_latency", last_start_cycle - req_cycle, 1);
    check_output("blk_id", log_id[log_id.size() - 1], 1);
    busy_force = 1; ifc.tx_busy = 1'b1;
    tick(); tick();
    busy_force = 0; ifc.tx_busy = 1'b0;
    wait_idle(10, "blk_idle");

    // Reset while in WAIT_LO aborts; afterwards requester 0 wins over 3.
    model_en = 1; busy_len = 20;
    ifc.req_data = 32'h00C3_0000;
    ifc.req = 4'b0100;
    wait_starts(n_start + 1, 10, "rmid_start");
    repeat (5) tick();
    check_output("rmid_busy_before", ifc.ctrl_busy, 1);
    rst_n = 1'b0;
    #1;
    check_output("rmid_ctrl_busy", ifc.ctrl_busy, 0);
    check_output("rmid_tx_data", ifc.tx_data, 8'h00);
    check_output("rmid_active_id", ifc.active_id, 0);
    check_output("rmid_tx_start", ifc.tx_start, 0);
    reset_model();
    base = n_start;
    tick(); tick();
    rst_n = 1'b1;
    repeat (3) tick();
    check_output("rmid_no_replay", n_start - base, 0);
    model_en = 1; busy_len = 3;
    ifc.req_data = 32'hBB00_00AA;
    ifc.req = 4'b1001;
    wait_starts(base + 2, 60, "rmid_starts");
    check_output("rmid_first", log_id[log_id.size() - 2], 0);
    check_output("rmid_second", log_id[log_id.size() - 1], 3);
    check_output("rmid_data", log_data[log_data.size() - 1], 8'hBB);
    wait_idle(50, "rmid_idle");

    check_output("ack_onehot", n_badack, 0);
    check_output("no_overlap", n_overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
